// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word reads, buffers returned
// words in a small ring and presents them to IF/ID, honouring stall and redirect.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] pc_plus4_out,
  output logic [31:0] instruction_out,
  output logic        flush_out
);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  logic [31:0]          fetch_pc;
  logic [31:0]          addr_q [BUF_DEPTH];
  logic [31:0]          data_q [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] filled_q;
  ptr_t                 alloc_ptr, fill_ptr, head_ptr;
  cnt_t                 occupancy, discard_cnt;
  cnt_t                 filled_cnt, unfilled_cnt;
  logic                 req_fire, rsp_live, rsp_fill, consume;
  logic [1:0]           unused_pc_lsb;

  assign unused_pc_lsb = redirect_pc[1:0];

  // Entries allocated but still waiting for their response
  always_comb begin
    filled_cnt = '0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      filled_cnt = filled_cnt + cnt_t'(filled_q[i]);
    end
  end
  assign unfilled_cnt = occupancy - filled_cnt;

  assign imem_req_valid = !reset && !redirect &&
                          ((SUM_W'(occupancy) + SUM_W'(discard_cnt)) < SUM_W'(BUF_DEPTH));
  assign imem_addr      = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing in flight is a protocol error and is ignored
  assign rsp_live = imem_rsp_valid && ((discard_cnt != '0) || (unfilled_cnt != '0));
  assign rsp_fill = rsp_live && !reset && !redirect && (discard_cnt == '0);

  assign if_valid        = !reset && !redirect && filled_q[head_ptr];
  assign pc_plus4_out    = if_valid ? (addr_q[head_ptr] + 32'd4) : '0;
  assign instruction_out = if_valid ? data_q[head_ptr] : '0;
  assign consume         = if_valid && !stall;
  assign flush_out       = redirect;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      alloc_ptr   <= '0;
      fill_ptr    <= '0;
      head_ptr    <= '0;
      occupancy   <= '0;
      discard_cnt <= '0;
      filled_q    <= '0;
    end else if (redirect) begin
      // Squashed in-flight requests still return; their words must be dropped
      fetch_pc    <= {redirect_pc[31:2], 2'b00};
      alloc_ptr   <= '0;
      fill_ptr    <= '0;
      head_ptr    <= '0;
      occupancy   <= '0;
      filled_q    <= '0;
      discard_cnt <= discard_cnt + unfilled_cnt - cnt_t'(rsp_live);
    end else begin
      if (req_fire) begin
        alloc_ptr <= alloc_ptr + ptr_t'(1);
        fetch_pc  <= fetch_pc + 32'd4;
      end
      if (rsp_live && (discard_cnt != '0)) begin
        discard_cnt <= discard_cnt - cnt_t'(1);
      end
      if (rsp_fill) begin
        filled_q[fill_ptr] <= 1'b1;
        fill_ptr           <= fill_ptr + ptr_t'(1);
      end
      if (consume) begin
        filled_q[head_ptr] <= 1'b0;
        head_ptr           <= head_ptr + ptr_t'(1);
      end
      occupancy <= occupancy + cnt_t'(req_fire) - cnt_t'(consume);
    end
  end

  // Payload storage carries no reset; validity lives in filled_q
  always_ff @(posedge clk) begin
    if (req_fire) begin
      addr_q[alloc_ptr] <= fetch_pc;
    end
    if (rsp_fill) begin
      data_q[fill_ptr] <= imem_rsp_data;
    end
  end
endmodule
